n64adv2_dram_arbiter: RTL and testbench
=======================================

Name: n64adv2_dram_arbiter

Overview:
- Schedules the shared single-port SDRAM between two requesters: the scaler's input-frame write path and its output-line read path.
- Also schedules periodic auto-refresh.
- Sits in the PPU DRAM clock domain, between the scaler FIFO logic and the SDRAM command/sequencer controller.
- Grants one burst at a time and tracks it to completion.

Parameters:
- ADDR_W, 22, word address width (bank+row+column).
- LEN_W, 4, burst length field width (burst of len+1 words).
- REF_INTERVAL, 1500, DRAM_CLK_i cycles per refresh obligation.
- WR_STARVE_MAX, 255, wait-cycle limit after which a pending write outranks a normal read.

Ports:
- DRAM_CLK_i  in  1  SDRAM-domain clock.
- DRAM_nRST_i  in  1  asynchronous active-low reset.
- init_done_i  in  1  SDRAM power-up/mode-register sequence finished.
- wr_req_i  in  1  write burst request; held until granted.
- wr_addr_i  in  ADDR_W  write start address.
- wr_len_i  in  LEN_W  write burst length-1.
- wr_gnt_o  out  1  one-cycle grant pulse to writer.
- rd_req_i  in  1  read burst request; held until granted.
- rd_urgent_i  in  1  output line buffer below threshold.
- rd_addr_i  in  ADDR_W  read start address.
- rd_len_i  in  LEN_W  read burst length-1.
- rd_gnt_o  out  1  one-cycle grant pulse to reader.
- cmd_valid_o  out  1  command to sequencer valid.
- cmd_ready_i  in  1  sequencer accepts command.
- cmd_op_o  out  2  00 none, 01 write, 10 read, 11 refresh.
- cmd_addr_o  out  ADDR_W  latched address.
- cmd_len_o  out  LEN_W  latched length-1.
- cmd_done_i  in  1  one-cycle pulse: accepted command completed.
- ref_debt_o  out  2  outstanding refresh obligations.
- ref_overrun_o  out  1  sticky: refresh obligation lost.

Behaviour:
- Reset values (async on DRAM_nRST_i low):
  - all outputs 0 (cmd_op_o=00);
  - state IDLE, refresh counter 0, debt 0, starve counter 0, overrun 0.
- Reset mid-burst aborts tracking. The sequencer is reset by the same net.
- FSM states: IDLE, ISSUE, BUSY.
- IDLE:
  - If init_done_i=0, no grant and stay in IDLE.
  - Otherwise pick the first true condition below. Capture op/addr/len, go to ISSUE, and assert cmd_valid_o plus the matching gnt pulse on the next cycle (latency from request sampled in IDLE to gnt/cmd_valid = 1 cycle):
    1. debt>=2 → refresh;
    2. rd_req_i & rd_urgent_i → read;
    3. wr_req_i & starve>=WR_STARVE_MAX → write;
    4. rd_req_i → read;
    5. wr_req_i → write;
    6. debt==1 → refresh.
  - No condition true: stay in IDLE.
- ISSUE:
  - cmd_valid_o=1 with cmd_op/addr/len stable until cmd_ready_i=1.
  - On acceptance, go to BUSY and drop cmd_valid_o next cycle.
- BUSY:
  - Wait for cmd_done_i, then go to IDLE. At least one IDLE cycle lies between bursts.
  - cmd_done_i seen in any other state is ignored.
- Grant pulse: wr_gnt_o or rd_gnt_o is high for exactly the cycle ISSUE is entered. Refresh grants produce no gnt pulse. A requester may keep req high for a back-to-back burst with new addr/len after gnt.
- Refresh counter:
  - Runs only while init_done_i=1; held at 0 otherwise.
  - Counts 0..REF_INTERVAL-1 and wraps. The wrap cycle is a tick.
  - Tick: debt+1, saturating at 3.
  - Tick while debt==3: set ref_overrun_o, cleared only by reset.
  - Refresh command accepted (cmd_ready_i in ISSUE with op 11): debt-1.
  - Tick and acceptance in the same cycle: debt unchanged.
- Starve counter:
  - Increments (saturating at WR_STARVE_MAX) each cycle wr_req_i=1 and no write grant occurs.
  - Clears on wr_gnt_o, or when wr_req_i=0.
- Widths: cmd_len_o for refresh = 0; cmd_addr_o for refresh = 0.

Test Plan:
- Reset/init:
  - Stimulus: release reset with init_done_i=0; assert wr_req_i and rd_req_i for 100 cycles.
  - Required: no gnt, cmd_valid_o=0, ref_debt_o=0.
- Single write:
  - Stimulus: init_done_i=1; wr_req_i with addr 0x012345, len 7; cmd_ready_i at ISSUE+2; cmd_done_i 10 cycles later.
  - Required: wr_gnt_o pulse 1 cycle after request; cmd_op_o=01, addr/len stable until ready; next grant no earlier than 1 cycle after done.
- Priority:
  - Stimulus: wr_req_i and rd_req_i simultaneous.
  - Required: read first.
  - Stimulus: add rd_urgent_i while starve>=255.
  - Required: urgent read still wins.
  - Stimulus: drop rd_urgent_i.
  - Required: starved write wins over plain read.
- Starvation:
  - Stimulus: WR_STARVE_MAX=8; continuous rd_req_i with 1-cycle bursts and wr_req_i held.
  - Required: write granted once starve reaches 8; counter then clears.
- Refresh:
  - Stimulus: REF_INTERVAL=16, no traffic.
  - Required: refresh issued after each tick (debt 1→0).
  - Stimulus: hold cmd_ready_i=0 across 3 ticks.
  - Required: ref_debt_o=3; 4th tick sets ref_overrun_o.
  - Stimulus: refresh accepted on a tick cycle.
  - Required: debt unchanged.
- Reset mid-burst:
  - Stimulus: assert DRAM_nRST_i low while in BUSY.
  - Required: all outputs 0 immediately (asynchronous); after release, IDLE with debt 0.

Source files
------------

// File: rtl/n64adv2_dram_arbiter_if.sv
// Request, grant and sequencer-command signals around the SDRAM arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment, which is the requesters plus the sequencer.
interface n64adv2_dram_arbiter_if #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned LEN_W  = 4
);

  logic              init_done_i;
  logic              wr_req_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [LEN_W-1:0]  wr_len_i;
  logic              wr_gnt_o;
  logic              rd_req_i;
  logic              rd_urgent_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [LEN_W-1:0]  rd_len_i;
  logic              rd_gnt_o;
  logic              cmd_valid_o;
  logic              cmd_ready_i;
  logic [1:0]        cmd_op_o;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic [LEN_W-1:0]  cmd_len_o;
  logic              cmd_done_i;
  logic [1:0]        ref_debt_o;
  logic              ref_overrun_o;

  modport slave (
    input  init_done_i,
    input  wr_req_i, wr_addr_i, wr_len_i,
    output wr_gnt_o,
    input  rd_req_i, rd_urgent_i, rd_addr_i, rd_len_i,
    output rd_gnt_o,
    output cmd_valid_o, cmd_op_o, cmd_addr_o, cmd_len_o,
    input  cmd_ready_i, cmd_done_i,
    output ref_debt_o, ref_overrun_o
  );

  modport master (
    output init_done_i,
    output wr_req_i, wr_addr_i, wr_len_i,
    input  wr_gnt_o,
    output rd_req_i, rd_urgent_i, rd_addr_i, rd_len_i,
    input  rd_gnt_o,
    input  cmd_valid_o, cmd_op_o, cmd_addr_o, cmd_len_o,
    output cmd_ready_i, cmd_done_i,
    input  ref_debt_o, ref_overrun_o
  );

endinterface

// File: rtl/n64adv2_dram_arbiter.sv
// Shares the single-port SDRAM between the scaler's frame-write path and its
// line-read path, and interleaves periodic auto-refresh. One burst is granted at a
// time and is tracked until the sequencer reports that it is done.
module n64adv2_dram_arbiter #(
  parameter int unsigned ADDR_W        = 22,
  parameter int unsigned LEN_W         = 4,
  parameter int unsigned REF_INTERVAL  = 1500,
  parameter int unsigned WR_STARVE_MAX = 255
) (
  input  logic                   DRAM_CLK_i,
  input  logic                   DRAM_nRST_i,
  n64adv2_dram_arbiter_if.slave  bus
);

  localparam int unsigned REF_CNT_W = $clog2(REF_INTERVAL);
  localparam int unsigned STARVE_W  = $clog2(WR_STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_REF  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY
  } state_e;

  state_e               state_q;
  op_e                  cmd_op_q;
  logic                 cmd_valid_q;
  logic [ADDR_W-1:0]    cmd_addr_q;
  logic [LEN_W-1:0]     cmd_len_q;
  logic                 wr_gnt_q;
  logic                 rd_gnt_q;
  logic [REF_CNT_W-1:0] ref_cnt_q;
  logic [1:0]           debt_q;
  logic                 overrun_q;
  logic [STARVE_W-1:0]  starve_q;

  logic ref_tick_c;
  logic ref_acc_c;
  op_e  pick_op_c;

  assign bus.wr_gnt_o      = wr_gnt_q;
  assign bus.rd_gnt_o      = rd_gnt_q;
  assign bus.cmd_valid_o   = cmd_valid_q;
  assign bus.cmd_op_o      = cmd_op_q;
  assign bus.cmd_addr_o    = cmd_addr_q;
  assign bus.cmd_len_o     = cmd_len_q;
  assign bus.ref_debt_o    = debt_q;
  assign bus.ref_overrun_o = overrun_q;

  // Refresh obligations arise on the counter wrap and are paid off when the sequencer accepts a refresh.
  assign ref_tick_c = bus.init_done_i && (ref_cnt_q == REF_CNT_W'(REF_INTERVAL - 1));
  assign ref_acc_c  = (state_q == ST_ISSUE) && bus.cmd_ready_i && (cmd_op_q == OP_REF);

  // Fixed-priority choice of the next burst, evaluated while idle.
  always_comb begin
    pick_op_c = OP_NONE;
    if (debt_q >= 2'd2)
      pick_op_c = OP_REF;
    else if (bus.rd_req_i && bus.rd_urgent_i)
      pick_op_c = OP_RD;
    else if (bus.wr_req_i && (starve_q >= STARVE_W'(WR_STARVE_MAX)))
      pick_op_c = OP_WR;
    else if (bus.rd_req_i)
      pick_op_c = OP_RD;
    else if (bus.wr_req_i)
      pick_op_c = OP_WR;
    else if (debt_q == 2'd1)
      pick_op_c = OP_REF;
  end

  // Burst scheduler: capture the choice, offer it to the sequencer, then wait for completion.
  always_ff @(posedge DRAM_CLK_i or negedge DRAM_nRST_i) begin
    if (!DRAM_nRST_i) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_NONE;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      wr_gnt_q    <= 1'b0;
      rd_gnt_q    <= 1'b0;
    end else begin
      wr_gnt_q <= 1'b0;
      rd_gnt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.init_done_i && (pick_op_c != OP_NONE)) begin
            state_q     <= ST_ISSUE;
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= pick_op_c;
            case (pick_op_c)
              OP_WR: begin
                cmd_addr_q <= bus.wr_addr_i;
                cmd_len_q  <= bus.wr_len_i;
                wr_gnt_q   <= 1'b1;
              end
              OP_RD: begin
                cmd_addr_q <= bus.rd_addr_i;
                cmd_len_q  <= bus.rd_len_i;
                rd_gnt_q   <= 1'b1;
              end
              default: begin
                cmd_addr_q <= '0;
                cmd_len_q  <= '0;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (bus.cmd_ready_i) begin
            state_q     <= ST_BUSY;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_NONE;
          end
        end
        ST_BUSY: begin
          if (bus.cmd_done_i)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The refresh interval timer runs only once the SDRAM is initialised.
  always_ff @(posedge DRAM_CLK_i or negedge DRAM_nRST_i) begin
    if (!DRAM_nRST_i)
      ref_cnt_q <= '0;
    else if (!bus.init_done_i || ref_tick_c)
      ref_cnt_q <= '0;
    else
      ref_cnt_q <= ref_cnt_q + REF_CNT_W'(1);
  end

  // Refresh debt saturates at 3. A tick while the debt is already at 3 means an obligation is lost.
  always_ff @(posedge DRAM_CLK_i or negedge DRAM_nRST_i) begin
    if (!DRAM_nRST_i) begin
      debt_q    <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      case ({ref_tick_c, ref_acc_c})
        2'b10: if (debt_q != 2'd3) debt_q <= debt_q + 2'd1;
        2'b01: debt_q <= debt_q - 2'd1;
        default: ;
      endcase
      if (ref_tick_c && (debt_q == 2'd3))
        overrun_q <= 1'b1;
    end
  end

  // Counts how long a pending write has waited. It clears on a write grant or when the request drops.
  always_ff @(posedge DRAM_CLK_i or negedge DRAM_nRST_i) begin
    if (!DRAM_nRST_i)
      starve_q <= '0;
    else if (!bus.wr_req_i || wr_gnt_q)
      starve_q <= '0;
    else if (starve_q < STARVE_W'(WR_STARVE_MAX))
      starve_q <= starve_q + STARVE_W'(1);
  end

endmodule

// File: tb/tb_n64adv2_dram_arbiter.sv
// Bench for the SDRAM arbiter. A behavioural model is stepped on every clock edge,
// and each falling edge compares the outputs against it. Directed phases add
// hand-computed expectations. Randomized phases exercise arbitrary traffic.
module tb_n64adv2_dram_arbiter;

  localparam int unsigned ADDR_W        = 22;
  localparam int unsigned LEN_W         = 4;
  localparam int unsigned REF_INTERVAL  = 32;
  localparam int unsigned WR_STARVE_MAX = 8;

  logic DRAM_CLK_w  = 1'b0;
  logic DRAM_nRST_w = 1'b0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  n64adv2_dram_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  n64adv2_dram_arbiter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W),
    .REF_INTERVAL(REF_INTERVAL), .WR_STARVE_MAX(WR_STARVE_MAX)
  ) dut (
    .DRAM_CLK_i (DRAM_CLK_w),
    .DRAM_nRST_i(DRAM_nRST_w),
    .bus        (bus)
  );

  always #5 DRAM_CLK_w = ~DRAM_CLK_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_offered: a command is on offer and waiting for acceptance.
  // m_outstanding: a command was accepted and is waiting for its done pulse.
  int                m_run = 0;
  int                m_debt = 0;
  int                m_starve = 0;
  bit                m_overrun = 0;
  bit                m_offered = 0;
  bit                m_outstanding = 0;
  bit                m_wr_gnt = 0;
  bit                m_rd_gnt = 0;
  int                m_op = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [LEN_W-1:0]  m_len = '0;
  bit                m_tick;
  bit                m_acc;
  int                m_choice;

  // The return codes are 0 none, 1 write, 2 read and 3 refresh.
  function automatic int pick(int debt, int starve, bit wr, bit rd, bit urg);
    if (debt >= 2) return 3;
    if (rd && urg) return 2;
    if (wr && starve >= int'(WR_STARVE_MAX)) return 1;
    if (rd) return 2;
    if (wr) return 1;
    if (debt == 1) return 3;
    return 0;
  endfunction

  initial forever begin
    @(posedge DRAM_CLK_w or negedge DRAM_nRST_w);
    if (!DRAM_nRST_w) begin
      m_run = 0; m_debt = 0; m_starve = 0; m_overrun = 0;
      m_offered = 0; m_outstanding = 0; m_wr_gnt = 0; m_rd_gnt = 0;
      m_op = 0; m_addr = '0; m_len = '0;
    end else begin
      m_choice = pick(m_debt, m_starve, bus.wr_req_i, bus.rd_req_i, bus.rd_urgent_i);
      m_tick = bus.init_done_i && ((m_run + 1) % int'(REF_INTERVAL) == 0);
      m_run = bus.init_done_i ? m_run + 1 : 0;
      m_acc = m_offered && bus.cmd_ready_i && (m_op == 3);
      if (m_tick && m_debt == 3) m_overrun = 1;
      m_debt = m_debt + int'(m_tick) - int'(m_acc);
      if (m_debt > 3) m_debt = 3;
      if (!bus.wr_req_i || m_wr_gnt) m_starve = 0;
      else if (m_starve < int'(WR_STARVE_MAX)) m_starve = m_starve + 1;
      m_wr_gnt = 0;
      m_rd_gnt = 0;
      if (m_offered) begin
        if (bus.cmd_ready_i) begin m_offered = 0; m_outstanding = 1; end
      end else if (m_outstanding) begin
        if (bus.cmd_done_i) m_outstanding = 0;
      end else if (bus.init_done_i && m_choice != 0) begin
        m_offered = 1;
        m_op = m_choice;
        if (m_choice == 1) begin m_addr = bus.wr_addr_i; m_len = bus.wr_len_i; m_wr_gnt = 1; end
        else if (m_choice == 2) begin m_addr = bus.rd_addr_i; m_len = bus.rd_len_i; m_rd_gnt = 1; end
        else begin m_addr = '0; m_len = '0; end
      end
    end
  end

  // Compares every output against the model on each falling edge.
  initial forever begin
    @(negedge DRAM_CLK_w);
    check("wr_gnt", 32'(bus.wr_gnt_o), 32'(m_wr_gnt));
    check("rd_gnt", 32'(bus.rd_gnt_o), 32'(m_rd_gnt));
    check("cmd_valid", 32'(bus.cmd_valid_o), 32'(m_offered));
    check("cmd_op", 32'(bus.cmd_op_o), m_offered ? 32'(m_op) : 32'd0);
    if (m_offered) begin
      check("cmd_addr", 32'(bus.cmd_addr_o), 32'(m_addr));
      check("cmd_len", 32'(bus.cmd_len_o), 32'(m_len));
    end
    check("ref_debt", 32'(bus.ref_debt_o), 32'(m_debt));
    check("ref_overrun", 32'(bus.ref_overrun_o), 32'(m_overrun));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge DRAM_CLK_w);
  endtask

  task automatic idle_inputs();
    bus.init_done_i = 1'b0;
    bus.wr_req_i = 1'b0; bus.wr_addr_i = '0; bus.wr_len_i = '0;
    bus.rd_req_i = 1'b0; bus.rd_urgent_i = 1'b0; bus.rd_addr_i = '0; bus.rd_len_i = '0;
    bus.cmd_ready_i = 1'b0; bus.cmd_done_i = 1'b0;
  endtask

  // Accepts the command that is on offer and completes it one cycle later. This leaves the DUT idle.
  task automatic finish_burst();
    bus.cmd_ready_i = 1'b1; cyc(1);
    bus.cmd_ready_i = 1'b0; bus.cmd_done_i = 1'b1; cyc(1);
    bus.cmd_done_i = 1'b0;
  endtask

  // Serves any pending refresh, then restarts the refresh timer from zero.
  task automatic drain();
    bus.wr_req_i = 1'b0; bus.rd_req_i = 1'b0; bus.rd_urgent_i = 1'b0;
    bus.init_done_i = 1'b1; bus.cmd_ready_i = 1'b1; bus.cmd_done_i = 1'b1;
    cyc(12);
    bus.cmd_ready_i = 1'b0; bus.cmd_done_i = 1'b0; bus.init_done_i = 1'b0;
    cyc(1);
    bus.init_done_i = 1'b1;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      bus.init_done_i = ($urandom_range(0, 99) != 0);
      bus.wr_req_i    = 1'($urandom_range(0, 1));
      bus.rd_req_i    = 1'($urandom_range(0, 1));
      bus.rd_urgent_i = ($urandom_range(0, 2) == 0);
      bus.wr_addr_i   = ADDR_W'($urandom);
      bus.rd_addr_i   = ADDR_W'($urandom);
      bus.wr_len_i    = LEN_W'($urandom);
      bus.rd_len_i    = LEN_W'($urandom);
      bus.cmd_ready_i = ($urandom_range(0, 2) == 0);
      bus.cmd_done_i  = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen;
    int rd_cnt;
    bit got;
    idle_inputs();
    DRAM_nRST_w = 1'b0;
    cyc(3);
    DRAM_nRST_w = 1'b1;

    // Reset/init: no grants and no debt while init_done is low.
    bus.wr_req_i = 1'b1; bus.rd_req_i = 1'b1;
    seen = 0;
    repeat (100) begin
      cyc(1);
      if (bus.wr_gnt_o || bus.rd_gnt_o || bus.cmd_valid_o) seen++;
    end
    check("init_no_activity", 32'(seen), 32'd0);
    check("init_debt", 32'(bus.ref_debt_o), 32'd0);

    // Single write: the grant comes one cycle after the request, and the command is held until ready.
    bus.rd_req_i = 1'b0;
    bus.wr_addr_i = 22'h012345; bus.wr_len_i = 4'd7;
    bus.init_done_i = 1'b1;
    cyc(1);
    check("wr_gnt_latency", 32'(bus.wr_gnt_o), 32'd1);
    check("wr_op", 32'(bus.cmd_op_o), 32'd1);
    check("wr_addr", 32'(bus.cmd_addr_o), 32'h012345);
    check("wr_len", 32'(bus.cmd_len_o), 32'd7);
    bus.wr_addr_i = 22'h02AAAA; bus.wr_len_i = 4'd3;
    cyc(1);
    check("wr_gnt_single_pulse", 32'(bus.wr_gnt_o), 32'd0);
    check("wr_addr_stable", 32'(bus.cmd_addr_o), 32'h012345);
    check("wr_valid_held", 32'(bus.cmd_valid_o), 32'd1);
    bus.cmd_ready_i = 1'b1;
    cyc(1);
    bus.cmd_ready_i = 1'b0;
    check("wr_valid_dropped", 32'(bus.cmd_valid_o), 32'd0);
    cyc(9);
    bus.cmd_done_i = 1'b1;
    cyc(1);
    bus.cmd_done_i = 1'b0;
    check("wr_no_gnt_in_gap", 32'(bus.wr_gnt_o), 32'd0);
    cyc(1);
    check("wr_b2b_gnt", 32'(bus.wr_gnt_o), 32'd1);
    check("wr_b2b_addr", 32'(bus.cmd_addr_o), 32'h02AAAA);
    bus.wr_req_i = 1'b0;
    finish_burst();

    // Priority: plain read before write, urgent read over a starved write, then the starved write.
    drain();
    bus.wr_req_i = 1'b1; bus.rd_req_i = 1'b1; bus.rd_urgent_i = 1'b0;
    bus.rd_addr_i = 22'h000100; bus.rd_len_i = 4'd2;
    bus.wr_addr_i = 22'h3F0000; bus.wr_len_i = 4'd5;
    cyc(1);
    check("prio_read_first", 32'(bus.cmd_op_o), 32'd2);
    check("prio_read_first_gnt", 32'(bus.rd_gnt_o), 32'd1);
    bus.rd_urgent_i = 1'b1;
    finish_burst(); cyc(1);
    finish_burst(); cyc(1);
    finish_burst(); cyc(1);
    check("prio_urgent_beats_starved", 32'(bus.cmd_op_o), 32'd2);
    bus.rd_urgent_i = 1'b0;
    finish_burst(); cyc(1);
    check("prio_starved_write", 32'(bus.cmd_op_o), 32'd1);
    check("prio_starved_write_addr", 32'(bus.cmd_addr_o), 32'h3F0000);
    bus.wr_req_i = 1'b0; bus.rd_req_i = 1'b0;
    finish_burst();

    // Starvation: with 3-cycle read bursts, three reads go ahead of each write.
    drain();
    bus.rd_req_i = 1'b1; bus.wr_req_i = 1'b1;
    bus.cmd_ready_i = 1'b1; bus.cmd_done_i = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      rd_cnt = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        cyc(1);
        if (bus.rd_gnt_o) rd_cnt++;
        if (bus.wr_gnt_o) got = 1;
      end
      check("starve_write_granted", 32'(got), 32'd1);
      check("starve_reads_before_write", 32'(rd_cnt), 32'd3);
    end
    bus.rd_req_i = 1'b0; bus.wr_req_i = 1'b0;
    cyc(4);
    bus.cmd_ready_i = 1'b0; bus.cmd_done_i = 1'b0;

    random_phase(3000);

    // Reset mid-burst: the outputs clear asynchronously.
    bus.wr_req_i = 1'b0; bus.rd_req_i = 1'b0; bus.rd_urgent_i = 1'b0;
    bus.init_done_i = 1'b1; bus.cmd_ready_i = 1'b1; bus.cmd_done_i = 1'b1;
    cyc(15);
    bus.cmd_done_i = 1'b0;
    bus.rd_req_i = 1'b1; bus.rd_addr_i = 22'h2ABCDE; bus.rd_len_i = 4'd9;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(1);
      if (bus.rd_gnt_o) got = 1;
    end
    bus.rd_req_i = 1'b0;
    check("midburst_read_granted", 32'(got), 32'd1);
    cyc(2);
    @(posedge DRAM_CLK_w);
    #2 DRAM_nRST_w = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.cmd_valid_o), 32'd0);
    check("async_rst_op", 32'(bus.cmd_op_o), 32'd0);
    check("async_rst_addr", 32'(bus.cmd_addr_o), 32'd0);
    check("async_rst_len", 32'(bus.cmd_len_o), 32'd0);
    check("async_rst_debt", 32'(bus.ref_debt_o), 32'd0);
    check("async_rst_overrun", 32'(bus.ref_overrun_o), 32'd0);
    idle_inputs();
    cyc(2);
    DRAM_nRST_w = 1'b1;
    cyc(2);
    check("post_rst_idle", 32'(bus.cmd_valid_o), 32'd0);
    check("post_rst_debt", 32'(bus.ref_debt_o), 32'd0);

    // Refresh: tick timing, debt accumulation, overrun, and a tick that coincides with an acceptance.
    bus.init_done_i = 1'b1; bus.cmd_ready_i = 1'b1;
    for (int c = 1; c <= 195; c++) begin
      cyc(1);
      case (c)
        31:  check("ref_debt_before_tick", 32'(bus.ref_debt_o), 32'd0);
        32:  check("ref_debt_after_tick", 32'(bus.ref_debt_o), 32'd1);
        33: begin
          check("ref_valid", 32'(bus.cmd_valid_o), 32'd1);
          check("ref_op", 32'(bus.cmd_op_o), 32'd3);
          check("ref_addr_len", 32'({bus.cmd_addr_o, bus.cmd_len_o}), 32'd0);
          check("ref_no_gnt", 32'(bus.wr_gnt_o | bus.rd_gnt_o), 32'd0);
        end
        34: begin
          check("ref_debt_paid", 32'(bus.ref_debt_o), 32'd0);
          bus.cmd_ready_i = 1'b0; bus.cmd_done_i = 1'b1;
        end
        35:  bus.cmd_done_i = 1'b0;
        130: begin
          check("ref_debt_saturated", 32'(bus.ref_debt_o), 32'd3);
          check("ref_no_overrun_yet", 32'(bus.ref_overrun_o), 32'd0);
        end
        160: check("ref_overrun_set", 32'(bus.ref_overrun_o), 32'd1);
        191: bus.cmd_ready_i = 1'b1;
        192: begin
          check("ref_tick_and_accept", 32'(bus.ref_debt_o), 32'd3);
          bus.cmd_ready_i = 1'b0; bus.cmd_done_i = 1'b1;
        end
        193: bus.cmd_done_i = 1'b0;
        default: ;
      endcase
    end

    random_phase(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
